// File: rtl/apb_slave_ram_pkg.sv
// Shared types and default bus widths for the APB slave RAM.
// State encoding is a one-bit enum: IDLE waits for a setup phase and
// ACCESS runs the wait-state countdown.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_t;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

endpackage

// File: rtl/apb_slave_ram_if.sv
// APB bus bundle between apb_master and apb_slave_ram.
// The master modport drives the request signals.
// The slave modport drives PRDATA/PREADY/PSLVERR.
interface apb_slave_ram_if #(
  parameter int ADDR_WIDTH = apb_pkg::APB_ADDR_W,
  parameter int DATA_WIDTH = apb_pkg::APB_DATA_W
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_ram_array.sv
// apb_ram_array: single-port word RAM behind the APB slave.
// Write is synchronous and read is asynchronous through the same address.
// A synchronous reset clears every word to zero.
module apb_ram_array
  import apb_pkg::*;
#(
  parameter  int DEPTH      = 64,
  parameter  int DATA_WIDTH = APB_DATA_W,
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Clear all words on reset, otherwise commit a write when enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/apb_slave_ram.sv
// apb_slave_ram: APB slave with on-chip RAM and WAIT_STATES wait states.
// Optional macro APB_SLAVE_PSLVERR_EN changes out-of-range handling.
// - When it is defined, an out-of-range access completes with PSLVERR=1,
//   the write is dropped and PRDATA is 0.
// - When it is not defined, the address wraps modulo DEPTH.
module apb_slave_ram
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_W,
  parameter int DATA_WIDTH  = APB_DATA_W,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input logic             PCLK,
  input logic             PRESET,
  apb_slave_ram_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(WAIT_STATES + 2);
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);

  apb_slv_state_t        r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic                  w_setup;
  logic                  w_ready;
  logic                  w_complete;
  logic                  w_live_err;
  logic                  w_lat_err;
  logic [IDX_W-1:0]      w_live_idx;
  logic [IDX_W-1:0]      w_lat_idx;
  logic [IDX_W-1:0]      w_mem_addr;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  // Word index: modulo DEPTH, which is the identity for in-range addresses.
  assign w_live_idx = IDX_W'({1'b0, bus.PADDR} % DEPTH_X);
  assign w_lat_idx  = IDX_W'({1'b0, r_addr} % DEPTH_X);

`ifdef APB_SLAVE_PSLVERR_EN
  assign w_live_err = ({1'b0, bus.PADDR} >= DEPTH_X);
  assign w_lat_err  = ({1'b0, r_addr} >= DEPTH_X);
`else
  assign w_live_err = 1'b0;
  assign w_lat_err  = 1'b0;
`endif

  // Decode handshake phases and steer the single RAM port.
  // The live address is used in IDLE for setup reads.
  // The latched address is used in ACCESS for write commits.
  always_comb begin
    w_setup    = bus.PSEL & ~bus.PENABLE;
    w_ready    = (r_state == ACCESS) && (r_cnt == '0);
    w_complete = w_ready & bus.PSEL & bus.PENABLE;
    w_mem_we   = w_complete & r_write & ~w_lat_err;
    if (r_state == ACCESS) begin
      w_mem_addr = w_lat_idx;
    end else begin
      w_mem_addr = w_live_idx;
    end
  end

  apb_ram_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Transfer FSM: latch the request at setup, count down wait states,
  // return to IDLE on completion or when PSEL is dropped.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_prdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state <= ACCESS;
            r_addr  <= bus.PADDR;
            r_write <= bus.PWRITE;
            r_wdata <= bus.PWDATA;
            r_cnt   <= CNT_LOAD;
            if (!bus.PWRITE) begin
              r_prdata <= w_live_err ? '0 : w_mem_rdata;
            end
          end
        end
        ACCESS: begin
          if (!bus.PSEL) begin
            r_state <= IDLE;
          end else if (bus.PENABLE) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_ONE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.PREADY  = w_ready;
  assign bus.PSLVERR = w_ready & w_lat_err;
  assign bus.PRDATA  = r_prdata;

endmodule

// File: tb/tb_apb_slave_ram.sv
// Self-checking bench for apb_slave_ram.
// It uses directed protocol scenarios plus randomized transfers.
// Results are compared against an array model of the RAM.
// A second instance with WAIT_STATES=0 covers zero-wait transfers.
module tb_apb_slave_ram;
  import apb_pkg::*;

  localparam int  AW     = 8;
  localparam int  DW     = 8;
  localparam int  DEPTH  = 64;
  localparam int  WS     = 1;
  localparam time PERIOD = 10;
`ifdef APB_SLAVE_PSLVERR_EN
  localparam bit  ERR_EN = 1'b1;
`else
  localparam bit  ERR_EN = 1'b0;
`endif

  logic PCLK;
  logic PRESET;
  int   n_checks;
  int   n_errors;
  time  t_setup;
  logic [DW-1:0] ref_mem [DEPTH];

  apb_slave_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
  apb_slave_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

  apb_slave_ram #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (DEPTH), .WAIT_STATES (WS)
  ) dut (
    .PCLK (PCLK), .PRESET (PRESET), .bus (bus)
  );

  apb_slave_ram #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (DEPTH), .WAIT_STATES (0)
  ) dut0 (
    .PCLK (PCLK), .PRESET (PRESET), .bus (bus0)
  );

  initial PCLK = 1'b0;
  always #(PERIOD / 2) PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // The reference model says where an address lands and whether it errors.
  function automatic bit ref_err(input logic [AW-1:0] a);
    return ERR_EN && (int'(a) >= DEPTH);
  endfunction

  function automatic int ref_idx(input logic [AW-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic go_idle();
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  // One complete transfer on bus.
  // It returns while PREADY=1, just before the completion edge.
  // This lets a following call form a back-to-back transfer.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int waits;
    bit e;
    @(negedge PCLK);
    t_setup     = $time;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = data;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    bus.PADDR   = AW'($urandom);
    bus.PWDATA  = DW'($urandom);
    bus.PWRITE  = 1'($urandom);
    waits = 0;
    while (bus.PREADY !== 1'b1 && waits < 20) begin
      @(negedge PCLK);
      waits++;
    end
    chk("wait_states", waits, WS);
    e = ref_err(addr);
    chk("pslverr", bus.PSLVERR, e);
    if (!wr) begin
      chk("prdata", bus.PRDATA, e ? '0 : ref_mem[ref_idx(addr)]);
    end else if (!e) begin
      ref_mem[ref_idx(addr)] = data;
    end
  endtask

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    time ta;
    n_checks = 0;
    n_errors = 0;
    ref_clear();
    bus.PSEL  = 1'b0; bus.PENABLE  = 1'b0; bus.PWRITE  = 1'b0; bus.PADDR  = '0; bus.PWDATA  = '0;
    bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b0; bus0.PADDR = '0; bus0.PWDATA = '0;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_pready", bus.PREADY, 1'b0);
    chk("rst_pslverr", bus.PSLVERR, 1'b0);
    chk("rst_prdata", bus.PRDATA, 8'h00);

    // First write: memory must not change before the completion edge.
    xfer(1'b1, 8'h01, 8'hAA);
    chk("mem_before_commit", dut.u_ram.r_mem[1], 8'h00);
    go_idle();
    chk("mem_after_commit", dut.u_ram.r_mem[1], 8'hAA);
    xfer(1'b0, 8'h01, 8'h00);
    go_idle();

    // Back-to-back writes, then reads; each transfer takes 2+WS cycles.
    xfer(1'b1, 8'h01, 8'hAA); ta = t_setup;
    xfer(1'b1, 8'h02, 8'hBB);
    chk("b2b_cycles", 32'((t_setup - ta) / PERIOD), 2 + WS);
    xfer(1'b1, 8'h03, 8'hCC);
    xfer(1'b0, 8'h01, 8'h00); ta = t_setup;
    xfer(1'b0, 8'h02, 8'h00);
    chk("b2b_rd_cycles", 32'((t_setup - ta) / PERIOD), 2 + WS);
    xfer(1'b0, 8'h03, 8'h00);
    go_idle();

    // Reset during the access phase of a write to address 4.
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h04; bus.PWDATA = 8'h55;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    chk("rst_mid_pready", bus.PREADY, 1'b0);
    ref_clear();
    xfer(1'b0, 8'h04, 8'h00);
    xfer(1'b0, 8'h01, 8'h00);
    go_idle();

    // Abort: PSEL is dropped during ACCESS, so the write must not land.
    xfer(1'b1, 8'h05, 8'h11);
    go_idle();
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h05; bus.PWDATA = 8'h99;
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_pready", bus.PREADY, 1'b0);
    @(negedge PCLK);
    chk("abort_pready2", bus.PREADY, 1'b0);
    xfer(1'b0, 8'h05, 8'h00);
    go_idle();

    // PENABLE high without a preceding setup phase.
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 8'h06; bus.PWDATA = 8'h66;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("no_setup_pready", bus.PREADY, 1'b0);
    end
    go_idle();
    xfer(1'b0, 8'h06, 8'h00);
    go_idle();

    // Out-of-range write 0x77 to 0x50: it either errors or aliases to 0x10.
    xfer(1'b1, 8'h50, 8'h77);
    go_idle();
    xfer(1'b0, 8'h10, 8'h00);
    xfer(1'b0, 8'h50, 8'h00);
    xfer(1'b0, 8'h3F, 8'h00);
    go_idle();

    // Randomized traffic with occasional idle gaps.
    for (int n = 0; n < 80; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      xfer(1'($urandom), a, DW'($urandom));
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();

    // Zero-wait instance: PREADY is high in the first access cycle.
    @(negedge PCLK);
    bus0.PSEL = 1'b1; bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b1; bus0.PADDR = 8'h07; bus0.PWDATA = 8'h3C;
    @(negedge PCLK);
    bus0.PENABLE = 1'b1;
    chk("ws0_wr_pready", bus0.PREADY, 1'b1);
    @(negedge PCLK);
    bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b0; bus0.PADDR = 8'h07;
    chk("ws0_setup_pready", bus0.PREADY, 1'b0);
    @(negedge PCLK);
    bus0.PENABLE = 1'b1;
    chk("ws0_rd_pready", bus0.PREADY, 1'b1);
    chk("ws0_rd_prdata", bus0.PRDATA, 8'h3C);
    @(negedge PCLK);
    bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0;
    chk("ws0_idle_pready", bus0.PREADY, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
